// File: rtl/div_seq_pkg.sv
// ============================================================================
// Module   : div_seq_pkg
// Brief    : Shared constants, state encoding and sign helper for div_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_seq_pkg;

  localparam int C_WIDTH = 32;
  localparam int C_ITERS = 32;
  localparam int C_CNT_W = $clog2(C_ITERS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Two's complement negation when neg is set; used both for |x| and the final fix-up.
  function automatic logic [C_WIDTH-1:0] neg_if(input logic neg, input logic [C_WIDTH-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module   : div_step
// Brief    : One restoring shift-compare-subtract iteration (combinational).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step
  import div_seq_pkg::*;
#(
  parameter int WIDTH = C_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_dividend_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_quo_bit
);

  logic             w_carry;
  logic [WIDTH-1:0] w_shift;
  logic             w_sub;

  // The bit shifted out of the top makes the shifted value exceed any divisor.
  assign w_carry   = i_rem[WIDTH-1];
  assign w_shift   = {i_rem[WIDTH-2:0], i_dividend_bit};
  assign w_sub     = w_carry || (w_shift >= i_divisor);
  assign o_rem     = w_sub ? (w_shift - i_divisor) : w_shift;
  assign o_quo_bit = w_sub;

endmodule

`default_nettype wire

// File: rtl/div_seq.sv
// ============================================================================
// Module   : div_seq
// Brief    : Sequential 32-bit signed/unsigned restoring divider with cancel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = C_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  state_t             r_state;
  logic [C_CNT_W-1:0] r_cnt;
  logic               r_signed;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_rem;
  logic               r_qneg;
  logic               r_rneg;
  logic [WIDTH-1:0]   w_rem_next;
  logic               w_qbit;

  assign busy = (r_state != S_IDLE);

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem          (r_rem),
    .i_dividend_bit (r_quo[WIDTH-1]),
    .i_divisor      (r_b),
    .o_rem          (w_rem_next),
    .o_quo_bit      (w_qbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_signed  <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else if (cancel && (r_state != S_IDLE)) begin
      r_state <= S_IDLE;
      done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !cancel) begin
            r_a      <= a;
            r_b      <= b;
            r_signed <= signed_op;
            r_state  <= S_PREP;
          end
        end
        S_PREP: begin
          if (r_b == '0) begin
            r_state <= S_DONE;
          end else begin
            // r_quo starts as |a| and shifts dividend bits out as quotient bits shift in.
            r_quo   <= neg_if(r_signed && r_a[WIDTH-1], r_a);
            r_b     <= neg_if(r_signed && r_b[WIDTH-1], r_b);
            r_rem   <= '0;
            r_cnt   <= '0;
            r_qneg  <= r_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
            r_rneg  <= r_signed && r_a[WIDTH-1];
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_rem <= w_rem_next;
          r_quo <= {r_quo[WIDTH-2:0], w_qbit};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == C_CNT_W'(C_ITERS - 1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          quotient  <= neg_if(r_qneg, r_quo);
          remainder <= neg_if(r_rneg, r_rem);
          div_zero  <= 1'b0;
          done      <= 1'b1;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          // Arriving from FIX the pulse is already up; a zero divisor registers its results here.
          if (done) begin
            done    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            quotient  <= '1;
            remainder <= r_a;
            div_zero  <= 1'b1;
            done      <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_seq.sv
// ============================================================================
// Module   : tb_div_seq
// Brief    : Directed self-checking bench for div_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic        cancel = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  div_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_op (signed_op),
    .a         (a),
    .b         (b),
    .cancel    (cancel),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch one operation (edge 1 = start sampled) and follow it to done.
  task automatic run_op(input string tag, input logic sop, input logic [31:0] aa,
                        input logic [31:0] bb, input int exp_lat, input logic [31:0] eq,
                        input logic [31:0] er, input logic ez, input bit poke);
    int n;
    bit busy_ok;
    signed_op = sop;
    a         = aa;
    b         = bb;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    n       = 1;
    busy_ok = busy && !done;
    while (!done && n < 60) begin
      if (poke && n == 5) begin
        start = 1'b1;
        a     = 32'd999;
        b     = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
      if (!busy) busy_ok = 1'b0;
    end
    start = 1'b0;
    chk({tag, " latency"}, 32'(n), 32'(exp_lat));
    chk({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    chk({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, ez});
  endtask

  // One edge after done: the pulse must have dropped and the divider be idle.
  task automatic after_done(input string tag);
    @(posedge clk);
    #1;
    chk({tag, " done pulse width"}, {31'd0, done}, 32'd0);
    chk({tag, " idle after done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset quotient", quotient, 32'd0);
    chk("reset remainder", remainder, 32'd0);
    chk("reset div_zero", {31'd0, div_zero}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Unsigned basic case, with a start poked mid-operation that must be ignored.
    run_op("divu 100/7", 1'b0, 32'd100, 32'd7, 35, 32'd14, 32'd2, 1'b0, 1'b1);
    after_done("divu 100/7");

    run_op("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 35, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
    after_done("div -7/2");
    run_op("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 35, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
    after_done("div 7/-2");
    run_op("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 35, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
    after_done("div ovf");
    run_op("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 35, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    after_done("divu max/1");
    run_op("divu 100/200", 1'b0, 32'd100, 32'd200, 35, 32'd0, 32'd100, 1'b0, 1'b0);
    after_done("divu 100/200");
    run_op("div -100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 35, 32'd14, 32'hFFFF_FFFE, 1'b0, 1'b0);
    after_done("div -100/-7");

    run_op("divu 5/0", 1'b0, 32'd5, 32'd0, 3, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0);
    after_done("divu 5/0");
    run_op("div -8/0", 1'b1, 32'hFFFF_FFF8, 32'd0, 3, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 1'b1, 1'b0);
    after_done("div -8/0");

    // Cancel while CALC holds counter value 10 (the cycle after edge 12).
    signed_op = 1'b0;
    a         = 32'd1000;
    b         = 32'd3;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    chk("pre-cancel busy", {31'd0, busy}, 32'd1);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    chk("cancel busy", {31'd0, busy}, 32'd0);
    chk("cancel done", {31'd0, done}, 32'd0);
    chk("cancel quotient held", quotient, 32'hFFFF_FFFF);
    chk("cancel remainder held", remainder, 32'hFFFF_FFF8);
    chk("cancel div_zero held", {31'd0, div_zero}, 32'd1);
    run_op("divu 7/7", 1'b0, 32'd7, 32'd7, 35, 32'd1, 32'd0, 1'b0, 1'b0);
    after_done("divu 7/7");

    // Cancel wins over start in IDLE.
    start  = 1'b1;
    cancel = 1'b1;
    a      = 32'd50;
    b      = 32'd5;
    @(posedge clk);
    #1;
    start  = 1'b0;
    cancel = 1'b0;
    chk("cancel+start idle", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of CALC.
    signed_op = 1'b0;
    a         = 32'd100;
    b         = 32'd7;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst busy", {31'd0, busy}, 32'd0);
    chk("async rst done", {31'd0, done}, 32'd0);
    chk("async rst quotient", quotient, 32'd0);
    chk("async rst remainder", remainder, 32'd0);
    chk("async rst div_zero", {31'd0, div_zero}, 32'd0);
    @(negedge clk) rst = 1'b0;
    run_op("post-rst divu 9/4", 1'b0, 32'd9, 32'd4, 35, 32'd2, 32'd1, 1'b0, 1'b0);
    after_done("post-rst divu 9/4");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 signed_op  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
REQ-006 a  input  32  dividend; sampled with start.
REQ-007 b  input  32  divisor; sampled with start.
REQ-008 cancel  input  1  pipeline flush; aborts any operation in progress.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse when quotient and remainder are valid.
REQ-011 quotient  output  32  result quotient; held until the next done.
REQ-012 remainder  output  32  result remainder; held until the next done.
REQ-013 div_zero  output  1  set with done when the divisor was 0; held with the results.

Function
REQ-014 States SHALL be IDLE, PREP, CALC, FIX and DONE.
REQ-015 IDLE -> PREP SHALL occur when start=1 and cancel=0; a, b and signed_op are latched on that edge.
REQ-016 PREP SHALL form |a| and |b| (when signed_op=1), record the quotient sign (sign(a) XOR sign(b)) and the remainder sign (sign(a)), clear the iteration counter, and go to CALC; if b=0 it SHALL go to DONE instead.
REQ-017 CALC SHALL perform one restoring shift-subtract step per cycle, MSB first, for exactly 32 cycles (counter 0..31), then go to FIX.
REQ-018 Each step SHALL shift the partial remainder left one bit, bringing in the next dividend bit, keeping the bit shifted out of bit 31; it subtracts the divisor when that bit is 1 or the shifted value is unsigned >= divisor, and the quotient bit is 1 exactly when it subtracts.
REQ-019 FIX SHALL negate the quotient and/or remainder per the recorded signs (signed_op=1 only), register the outputs, and go to DONE.
REQ-020 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-021 Latency: with start sampled at edge 1, done SHALL be high after edge 35 (divisor nonzero) or after edge 3 (divisor zero).
REQ-022 Divide by zero: quotient = 32'hFFFF_FFFF, remainder = a as latched, div_zero = 1.
REQ-023 Signed overflow: 0x8000_0000 / 0xFFFF_FFFF SHALL give quotient 0x8000_0000, remainder 0, div_zero 0.
REQ-024 When div_zero=0 the result SHALL satisfy quotient*b + remainder = a; the remainder is 0 or has the sign of a.
REQ-025 start while busy=1 SHALL be ignored and not queued.
REQ-026 cancel=1 in any state except IDLE SHALL force IDLE at the next edge, with no done pulse and quotient, remainder and div_zero unchanged.
REQ-027 cancel and start high together in IDLE: cancel wins and no operation starts.
REQ-028 A new start SHALL be accepted in the cycle immediately after done.

Reset
REQ-029 rst=1 SHALL immediately force IDLE and clear busy, done, quotient, remainder, div_zero, the counter and all working registers to 0, including during an operation.
REQ-030 After rst falls, the first start SHALL be honoured on the next edge.

Structure
REQ-031 A shared package SHALL hold the state encoding (3-bit), WIDTH and the iteration count constant (32).
REQ-032 One combinational sub-module, div_step, SHALL implement a single shift-compare-subtract iteration; div_seq holds the FSM, counter and sign handling.

Verification
REQ-033 DIVU 100/7 -> quotient 14, remainder 2, div_zero 0; done after edge 35 for exactly one cycle, busy high from edge 1 to edge 35.
REQ-034 DIV -7/2 -> quotient 0xFFFF_FFFD, remainder 0xFFFF_FFFF; DIV 7/-2 -> quotient 0xFFFF_FFFD, remainder 1.
REQ-035 DIV 0x8000_0000 / 0xFFFF_FFFF -> quotient 0x8000_0000, remainder 0; DIVU 0xFFFF_FFFF/1 -> quotient 0xFFFF_FFFF, remainder 0.
REQ-036 DIVU 5/0 -> quotient 0xFFFF_FFFF, remainder 5, div_zero 1, done after edge 3.
REQ-037 cancel in CALC cycle 10 -> IDLE next edge, no done, previous results held; then start at the next edge is accepted with DIVU 7/7 -> quotient 1, remainder 0.
REQ-038 rst asserted mid-CALC -> busy and all outputs 0 without waiting for a clock edge; a start while busy is ignored.
